// File: rtl/sume_pkg.sv
// Shared constants and the add-3 correction helper for the binary-to-BCD path.
package sume_pkg;

    localparam int unsigned NIB_W       = 4;
    localparam int unsigned ADD3_THRESH = 5;
    localparam int unsigned ADD3_OFFSET = 3;
    localparam int unsigned BCD_MAX     = 9;

    // Result of one correction cell: corrected nibble plus flags.
    typedef struct packed {
        logic [NIB_W-1:0] nib;
        logic             adj;
        logic             bcd_err;
    } sume_res_t;

    // Generic correction: add offset (mod 16) when nib >= thresh.
    // thresh is one bit wider than a nibble so a value of 16 disables correction.
    function automatic sume_res_t nib_correct(
        input logic [NIB_W-1:0] nib,
        input logic [NIB_W:0]   thresh,
        input logic [NIB_W-1:0] offset
    );
        sume_res_t res;
        res.adj     = ({1'b0, nib} >= thresh);
        res.nib     = res.adj ? NIB_W'(nib + offset) : nib;
        res.bcd_err = ({1'b0, nib} > (NIB_W+1)'(BCD_MAX));
        return res;
    endfunction

    // Default add-3 map used by the double-dabble converter.
    function automatic logic [NIB_W-1:0] add3(input logic [NIB_W-1:0] nib);
        sume_res_t res;
        res = nib_correct(nib, (NIB_W+1)'(ADD3_THRESH), NIB_W'(ADD3_OFFSET));
        return res.nib;
    endfunction

endpackage

// File: rtl/comp_sume3_core.sv
// Combinational nibble map v -> {out, adj, bcd_err}.
module comp_sume3_core
    import sume_pkg::*;
#(
    parameter int unsigned THRESH = ADD3_THRESH,
    parameter int unsigned OFFSET = ADD3_OFFSET
) (
    input  logic [NIB_W-1:0] nib_i,
    output sume_res_t        res_c
);

    localparam logic [NIB_W:0]   THR_W = (NIB_W+1)'(THRESH);
    localparam logic [NIB_W-1:0] OFS_W = NIB_W'(OFFSET);

    // Apply the threshold/offset correction and flag non-BCD codes.
    always_comb begin
        res_c = nib_correct(nib_i, THR_W, OFS_W);
    end

endmodule

// File: rtl/comp_sume3.sv
// Add-3 correction cell: optional output register around the combinational core.
module comp_sume3
    import sume_pkg::*;
#(
    parameter int unsigned REGISTERED = 1,
    parameter int unsigned THRESH     = ADD3_THRESH,
    parameter int unsigned OFFSET     = ADD3_OFFSET
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inA,
    input  logic             inB,
    input  logic             inC,
    input  logic             inD,
    output logic [NIB_W-1:0] out,
    output logic             adj,
    output logic             bcd_err
);

    logic [NIB_W-1:0] nib;
    sume_res_t        res_d;

    assign nib = {inA, inB, inC, inD};

    comp_sume3_core #(
        .THRESH (THRESH),
        .OFFSET (OFFSET)
    ) u_core (
        .nib_i (nib),
        .res_c (res_d)
    );

    generate
        if (REGISTERED != 0) begin : g_reg
            sume_res_t res_q;

            // Output register; synchronous reset wins over input sampling.
            always_ff @(posedge clk) begin
                if (rst) begin
                    res_q <= '0;
                end else begin
                    res_q <= res_d;
                end
            end

            assign out     = res_q.nib;
            assign adj     = res_q.adj;
            assign bcd_err = res_q.bcd_err;
        end else begin : g_comb
            // Clock and reset have no function in the zero-latency build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign out     = res_d.nib;
            assign adj     = res_d.adj;
            assign bcd_err = res_d.bcd_err;
        end
    endgenerate

endmodule

// File: tb/tb_comp_sume3.sv
// Self-checking bench for comp_sume3 (registered and combinational builds).
module tb_comp_sume3;

    logic       clk;
    logic       rst;
    logic [3:0] v;
    logic [3:0] out_r, out_c;
    logic       adj_r, adj_c;
    logic       err_r, err_c;

    int checks   = 0;
    int failures = 0;

    comp_sume3 #(.REGISTERED(1)) dut_r (
        .clk     (clk),
        .rst     (rst),
        .inA     (v[3]),
        .inB     (v[2]),
        .inC     (v[1]),
        .inD     (v[0]),
        .out     (out_r),
        .adj     (adj_r),
        .bcd_err (err_r)
    );

    comp_sume3 #(.REGISTERED(0)) dut_c (
        .clk     (clk),
        .rst     (rst),
        .inA     (v[3]),
        .inB     (v[2]),
        .inC     (v[1]),
        .inD     (v[0]),
        .out     (out_c),
        .adj     (adj_c),
        .bcd_err (err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: add 3 when value is 5 or more, wrap to 4 bits.
    function automatic int ref_out(input int val);
        return (val >= 5) ? ((val + 3) % 16) : val;
    endfunction

    function automatic int ref_adj(input int val);
        return (val >= 5) ? 1 : 0;
    endfunction

    function automatic int ref_err(input int val);
        return (val > 9) ? 1 : 0;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then check registered outputs for the value loaded at that edge
    // and combinational outputs for the current value.
    task automatic step(input string tag, input int val, input logic r);
        v   = 4'(val);
        rst = r;
        @(posedge clk);
        #1;
        check_eq({tag, ".out"}, int'(out_r), r ? 0 : ref_out(val));
        check_eq({tag, ".adj"}, int'(adj_r), r ? 0 : ref_adj(val));
        check_eq({tag, ".err"}, int'(err_r), r ? 0 : ref_err(val));
        check_eq({tag, ".cout"}, int'(out_c), ref_out(val));
        check_eq({tag, ".cadj"}, int'(adj_c), ref_adj(val));
        check_eq({tag, ".cerr"}, int'(err_c), ref_err(val));
    endtask

    initial begin
        v   = 4'd9;
        rst = 1'b1;

        // Reset holds outputs at zero even with v=9 present.
        step("rst", 9, 1'b1);
        step("rst2", 9, 1'b1);
        // First edge after release loads v=9 -> 12.
        step("rel", 9, 1'b0);
        check_eq("rel.lit", int'(out_r), 12);

        // Counter walk over all 16 codes, twice.
        for (int i = 0; i < 32; i++) begin
            step("walk", i % 16, 1'b0);
        end

        // Threshold and wrap boundaries against literal values.
        step("b4", 4, 1'b0);
        check_eq("b4.lit", int'(out_r), 4);
        check_eq("b4.adjlit", int'(adj_r), 0);
        step("b5", 5, 1'b0);
        check_eq("b5.lit", int'(out_r), 8);
        check_eq("b5.adjlit", int'(adj_r), 1);
        step("b12", 12, 1'b0);
        check_eq("b12.lit", int'(out_r), 15);
        check_eq("b12.errlit", int'(err_r), 1);
        step("b13", 13, 1'b0);
        check_eq("b13.lit", int'(out_r), 0);
        check_eq("b13.adjlit", int'(adj_r), 1);
        step("b15", 15, 1'b0);
        check_eq("b15.lit", int'(out_r), 2);

        // Mid-stream reset with v=7 streaming.
        step("mid0", 7, 1'b0);
        check_eq("mid0.lit", int'(out_r), 10);
        step("mid1", 7, 1'b1);
        check_eq("mid1.lit", int'(out_r), 0);
        step("mid2", 7, 1'b0);
        check_eq("mid2.lit", int'(out_r), 10);

        // Inputs change between edges: only the edge value counts.
        v = 4'd14;
        #2;
        step("glitch", 3, 1'b0);

        // Randomized stream with occasional reset.
        for (int i = 0; i < 200; i++) begin
            step("rnd", int'($urandom_range(15, 0)), ($urandom_range(7, 0) == 0));
        end

        // Combinational build: zero latency, indifferent to rst.
        @(negedge clk);
        v   = 4'd6;
        rst = 1'b0;
        #1;
        check_eq("comb6.out", int'(out_c), 9);
        check_eq("comb6.adj", int'(adj_c), 1);
        rst = 1'b1;
        #1;
        check_eq("comb6rst.out", int'(out_c), 9);
        v = 4'd13;
        #1;
        check_eq("comb13.out", int'(out_c), 0);
        check_eq("comb13.err", int'(err_c), 1);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
